// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the ID/EX hazard controller.
// Optional perf counters are enabled by HAZARD_PERF_CNT_EN.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } hz_state_t;

    localparam logic [4:0] XZR_IDX = 5'd31;

    // Writes to XZR never create a true dependency.
    function automatic logic load_use_hit(
        input logic       id_valid,
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic [4:0] rn,
        input logic [4:0] rm,
        input logic       uses_rm
    );
        logic src_match;
        src_match = (ex_rd == rn) || (uses_rm && (ex_rd == rm));
        return id_valid && ex_mem_read && (ex_rd != XZR_IDX) && src_match;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous reset.
// Used for the optional hazard perf counters.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use, branch-flush and multiply-occupancy control for ID/EX.
// Define HAZARD_PERF_CNT_EN to add stall/flush perf counters.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       Rn_if_id,
    input  logic [4:0]       Rm_if_id,
    input  logic             id_uses_Rm,
    input  logic [4:0]       ex_Rd,
    input  logic             ex_mem_read,
    input  logic             ex_is_mul,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_hold,
    output logic             ex_mem_bubble,
    output logic [1:0]       hz_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    if (MUL_LATENCY < 1 || MUL_LATENCY > 15 || CNT_W < 1) begin : g_bad_param
        $error("hazard_stall_ctrl: parameter out of range");
    end

    localparam bit MUL_MULTI = (MUL_LATENCY > 1);
    localparam logic [3:0] MUL_INIT =
        (MUL_LATENCY >= 2) ? 4'(MUL_LATENCY - 2) : 4'd0;
    localparam hz_state_t MUL_NEXT =
        (MUL_LATENCY == 2) ? MUL_DONE : MUL_BUSY;

    hz_state_t  state_q;
    hz_state_t  state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       load_use;

    assign load_use = load_use_hit(id_valid, ex_mem_read, ex_Rd,
                                   Rn_if_id, Rm_if_id, id_uses_Rm);

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_hold       = 1'b0;
        ex_mem_bubble = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;
        if (rst) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ex_is_mul && MUL_MULTI) begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        ex_hold       = 1'b1;
                        ex_mem_bubble = 1'b1;
                        cnt_d         = MUL_INIT;
                        state_d       = MUL_NEXT;
                    end else if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
                MUL_BUSY: begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    ex_hold       = 1'b1;
                    ex_mem_bubble = 1'b1;
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end
                    if (cnt_q <= 4'd1) begin
                        state_d = MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    // Multiply leaves EX now; ex_is_mul still refers to it.
                    if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (!pc_write),
        .count(stall_cycles)
    );

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (if_id_flush),
        .count(flush_count)
    );
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized + directed bench for hazard_stall_ctrl.
// Define HAZARD_PERF_CNT_EN to also cover the perf counters.
module tb_hazard_stall_ctrl;

    localparam int LAT = 4;
    localparam int CW  = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       uses_rm;
    logic [4:0] ex_rd;
    logic       mem_rd;
    logic       is_mul;
    logic       br;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       ex_hold;
    logic       ex_mem_bubble;
    logic [1:0] hz_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_count;
`endif

    int vectors = 0;
    int errors  = 0;

    // Reference state: hold cycles still owed to a multiply,
    // and whether this cycle is the release cycle.
    int     m_hold_left = 0;
    bit     m_done      = 1'b0;
    longint m_stall     = 0;
    longint m_flush     = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .MUL_LATENCY(LAT),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .Rn_if_id       (rn),
        .Rm_if_id       (rm),
        .id_uses_Rm     (uses_rm),
        .ex_Rd          (ex_rd),
        .ex_mem_read    (mem_rd),
        .ex_is_mul      (is_mul),
        .ex_branch_taken(br),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_bubble   (id_ex_bubble),
        .ex_hold        (ex_hold),
        .ex_mem_bubble  (ex_mem_bubble),
        .hz_state       (hz_state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    task automatic set_in(input bit r, input bit v,
                          input int n, input int m, input bit u,
                          input int d, input bit ld,
                          input bit mu, input bit b);
        rst      = r;
        id_valid = v;
        rn       = 5'(n);
        rm       = 5'(m);
        uses_rm  = u;
        ex_rd    = 5'(d);
        mem_rd   = ld;
        is_mul   = mu;
        br       = b;
    endtask

    // Called at posedge+1 with inputs driven; checks at negedge,
    // advances the reference, and returns at the next posedge+1.
    task automatic cyc(input logic [7:0] lit, input bit use_lit,
                       input string name);
        logic [7:0] got;
        logic [7:0] exp;
        bit  p, w, f, bb, h, mb, lu, enter;
        int  st;
        #4;
        p = 1; w = 1; f = 0; bb = 0; h = 0; mb = 0;
        st = (m_hold_left > 0) ? 1 : (m_done ? 2 : 0);
        lu = id_valid && mem_rd && (ex_rd != 5'd31) &&
             ((ex_rd == rn) || (uses_rm && ex_rd == rm));
        enter = (m_hold_left == 0) && !m_done && is_mul && (LAT > 1);
        if (!rst) begin
            if (m_hold_left > 0 || enter) begin
                p = 0; w = 0; h = 1; mb = 1;
            end else if (br) begin
                f = 1; bb = 1;
            end else if (lu) begin
                p = 0; w = 0; bb = 1;
            end
        end
        exp = {p, w, f, bb, h, mb, 2'(st)};
        got = {pc_write, if_id_write, if_id_flush, id_ex_bubble,
               ex_hold, ex_mem_bubble, hz_state};
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s model: got %h want %h", name, got, exp);
        end
        if (use_lit) begin
            vectors++;
            if (got !== lit) begin
                errors++;
                $display("FAIL %s literal: got %h want %h", name, got, lit);
            end
        end
`ifdef HAZARD_PERF_CNT_EN
        vectors++;
        if (stall_cycles !== CW'(m_stall) || flush_count !== CW'(m_flush)) begin
            errors++;
            $display("FAIL %s perf: got %0d/%0d want %0d/%0d", name,
                     stall_cycles, flush_count, m_stall, m_flush);
        end
`endif
        if (rst) begin
            m_hold_left = 0;
            m_done      = 0;
            m_stall     = 0;
            m_flush     = 0;
        end else begin
            m_stall += (p == 0) ? 1 : 0;
            m_flush += f ? 1 : 0;
            if (m_hold_left > 0) begin
                m_hold_left--;
                m_done = (m_hold_left == 0);
            end else if (enter) begin
                m_hold_left = LAT - 2;
                m_done      = (LAT == 2);
            end else begin
                m_done = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_reg();
        int r;
        r = int'($urandom_range(0, 7));
        return (r == 7) ? 31 : (r % 4);
    endfunction

    initial begin
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        cyc(8'hC0, 1, "reset0");
        cyc(8'hC0, 1, "reset1");

        set_in(0, 1, 3, 0, 0, 3, 1, 0, 0);
        cyc(8'h10, 1, "load_use");
        set_in(0, 1, 3, 0, 0, 3, 0, 0, 0);
        cyc(8'hC0, 1, "after_lu");
        set_in(0, 1, 31, 0, 0, 31, 1, 0, 0);
        cyc(8'hC0, 1, "xzr");
        set_in(0, 1, 1, 5, 0, 5, 1, 0, 0);
        cyc(8'hC0, 1, "rm_unused");
        set_in(0, 1, 1, 5, 1, 5, 1, 0, 0);
        cyc(8'h10, 1, "rm_used");
        set_in(0, 0, 3, 0, 0, 3, 1, 0, 0);
        cyc(8'hC0, 1, "id_invalid");
        set_in(0, 1, 3, 0, 0, 3, 1, 0, 1);
        cyc(8'hF0, 1, "br_vs_lu");

        set_in(0, 1, 0, 0, 0, 7, 0, 1, 0);
        cyc(8'h0C, 1, "mul_t0");
        cyc(8'h0D, 1, "mul_t1");
        cyc(8'h0D, 1, "mul_t2");
        cyc(8'hC2, 1, "mul_done");
        cyc(8'h0C, 1, "mul_retrig");
        set_in(0, 1, 0, 0, 0, 7, 0, 0, 0);
        cyc(8'h0D, 1, "mul2_t1");
        cyc(8'h0D, 1, "mul2_t2");
        cyc(8'hC2, 1, "mul2_done");
        cyc(8'hC0, 1, "mul2_idle");

        set_in(0, 1, 0, 0, 0, 7, 0, 1, 0);
        cyc(8'h0C, 1, "rmul_t0");
        set_in(0, 1, 0, 0, 0, 7, 0, 0, 0);
        cyc(8'h0D, 1, "rmul_t1");
        set_in(1, 1, 0, 0, 0, 7, 0, 0, 0);
        cyc(8'hC1, 1, "rst_mid_mul");
        set_in(0, 1, 0, 0, 0, 7, 0, 0, 0);
        cyc(8'hC0, 1, "after_rst");

`ifdef HAZARD_PERF_CNT_EN
        set_in(1, 1, 0, 0, 0, 7, 0, 0, 0);
        cyc(8'hC0, 1, "perf_rst");
        set_in(0, 1, 3, 0, 0, 3, 1, 0, 0);
        cyc(8'h10, 1, "perf_lu1");
        set_in(0, 1, 0, 0, 0, 7, 0, 0, 0);
        cyc(8'hC0, 1, "perf_gap1");
        set_in(0, 1, 3, 0, 0, 3, 1, 0, 0);
        cyc(8'h10, 1, "perf_lu2");
        set_in(0, 1, 0, 0, 0, 7, 0, 1, 0);
        cyc(8'h0C, 1, "perf_mul0");
        set_in(0, 1, 0, 0, 0, 7, 0, 0, 0);
        cyc(8'h0D, 1, "perf_mul1");
        cyc(8'h0D, 1, "perf_mul2");
        cyc(8'hC2, 1, "perf_muld");
        set_in(0, 1, 0, 0, 0, 7, 0, 0, 1);
        cyc(8'hF0, 1, "perf_br");
        set_in(0, 1, 0, 0, 0, 7, 0, 0, 0);
        #4;
        vectors++;
        if (stall_cycles !== CW'(5) || flush_count !== CW'(1)) begin
            errors++;
            $display("FAIL perf_total: got %0d/%0d want 5/1",
                     stall_cycles, flush_count);
        end
        #1;
        @(posedge clk);
        #1;
        set_in(1, 1, 0, 0, 0, 7, 0, 0, 0);
        m_hold_left = 0;
        m_done      = 0;
        m_stall     = 0;
        m_flush     = 0;
        cyc(8'hC0, 0, "perf_resync");
`endif

        for (int i = 0; i < 3000; i++) begin
            bit mu;
            bit b;
            mu = ($urandom_range(0, 99) < 15);
            b  = !mu && ($urandom_range(0, 99) < 15);
            set_in($urandom_range(0, 99) < 2,
                   $urandom_range(0, 3) != 0,
                   pick_reg(), pick_reg(),
                   $urandom_range(0, 1) == 1,
                   pick_reg(),
                   $urandom_range(0, 1) == 1,
                   mu, b);
            cyc(8'h00, 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard controller that drives the ID/EX register and its neighbours. It watches the IF/ID source registers and the outputs of the ID/EX register, and generates PC/IF-ID write enables, ID/EX bubble insertion, ID/EX hold, and IF/ID flush. It covers three cases: load-use interlocks, branch-taken flushes, and multi-cycle multiply occupancy of EX. It sits beside the ID/EX register in the 64-bit ARM pipeline and is the control end of that register's interface.

## Interface
Parameters:
- MUL_LATENCY, 4: cycles a multiply occupies EX (legal range 1..15).
- CNT_W, 32: width of the performance counters (only with HAZARD_PERF_CNT_EN).

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- id_valid  in  1  IF/ID holds a real instruction.
- Rn_if_id  in  5  Rn field of the instruction in ID.
- Rm_if_id  in  5  Rm field of the instruction in ID.
- id_uses_Rm  in  1  instruction in ID reads Rm.
- ex_Rd  in  5  destination register from ID/EX (linked or Rd).
- ex_mem_read  in  1  instruction in EX is a load.
- ex_is_mul  in  1  instruction in EX is a multiply.
- ex_branch_taken  in  1  branch in EX resolved taken.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_bubble  out  1  ID/EX loads all-zero struct_EX/struct_MEM/struct_WB.
- ex_hold  out  1  ID/EX register enable deasserted (contents frozen).
- ex_mem_bubble  out  1  EX/MEM loads zero control.
- hz_state  out  2  current FSM state (hz_state_t).
- stall_cycles  out  CNT_W  count of cycles with pc_write=0 (macro only).
- flush_count  out  CNT_W  count of cycles with if_id_flush=1 (macro only).

## Operation
- FSM states: IDLE=0, MUL_BUSY=1, MUL_DONE=2. Outputs are Mealy: a function of the current state and the current inputs.
- Default outputs: pc_write=1, if_id_write=1, all others 0.
- Load-use condition:
  - id_valid, ex_mem_read, and ex_Rd != 31.
  - ex_Rd == Rn_if_id, or (id_uses_Rm and ex_Rd == Rm_if_id).
- Priority in IDLE and MUL_DONE:
  1. ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1. Load-use is ignored.
  2. Load-use: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly that cycle.
- Multiply entry (IDLE only): ex_is_mul with MUL_LATENCY>1.
  - Assert ex_hold=1, ex_mem_bubble=1, pc_write=0, if_id_write=0.
  - Load counter with MUL_LATENCY-2.
  - Next state is MUL_DONE if MUL_LATENCY==2, else MUL_BUSY.
  - With MUL_LATENCY==1 the FSM never leaves IDLE.
  - Multiply entry takes priority over load-use.
- MUL_BUSY:
  - Same hold outputs as multiply entry.
  - Counter decrements each cycle; when the counter is 1, next state is MUL_DONE.
  - Load-use and ex_branch_taken are ignored.
- MUL_DONE:
  - ex_hold=0, so the multiply advances.
  - ex_is_mul is ignored, so the same multiply does not retrigger.
  - Load-use and branch logic evaluate normally.
  - Next state is IDLE.
- Counter: 4-bit, unsigned, never underflows.

## Timing
- Load-use stall: exactly 1 cycle per hazard; zero latency (same-cycle response).
- Multiply in EX first at cycle t: ex_hold high t..t+MUL_LATENCY-2, low at t+MUL_LATENCY-1.
- Reset values: hz_state=IDLE, counter=0, stall_cycles=0, flush_count=0.
- Outputs during a reset cycle: pc_write=1, if_id_write=1, all others 0.
- rst asserted mid-multiply: returns to IDLE on the next edge, with no residual hold.
- Back-to-back multiplies: second multiply in EX at t+MUL_LATENCY, seen in IDLE, retriggers normally.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles and flush_count ports exist.
  - Both are saturating CNT_W-bit counters and update on posedge.
  - stall_cycles increments when pc_write==0; flush_count increments when if_id_flush==1.
- HAZARD_PERF_CNT_EN undefined: both ports and all counter logic are absent; all other behaviour is identical.

## Structure
- Package structures gains:
  - hz_state_t (2-bit enum: IDLE, MUL_BUSY, MUL_DONE).
  - Constant XZR_IDX=5'd31.
- One sub-module, sat_counter (CNT_W, enable, synchronous reset), instantiated twice under the macro.

## Test plan
- Load-use: ex_mem_read=1, ex_Rd=3, Rn_if_id=3, id_valid=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle with ex_mem_read=0 -> defaults.
- XZR and unused Rm:
  - ex_Rd=31 matching Rn -> no stall.
  - ex_Rd=5=Rm_if_id with id_uses_Rm=0 -> no stall.
- Branch vs load-use in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1.
- MUL_LATENCY=4, ex_is_mul held -> ex_hold=1 for 3 cycles; hz_state 0→1→1→2→0; no retrigger in MUL_DONE.
- rst pulsed during the second MUL_BUSY cycle -> next cycle hz_state=0, ex_hold=0.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls, one 4-latency multiply, and 1 flush -> stall_cycles=5, flush_count=1.
